stage_writeback: RTL and testbench
==================================

STAGE_WRITEBACK -- requirements
Module: stage_writeback

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: cycles a load may wait for dmem_rvalid before it is faulted; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 mem_valid  input  1  memory-stage register holds a live instruction.
REQ-005 mem_rd  input  5  destination register index.
REQ-006 mem_alu_result  input  32  ALU result; for loads, the byte address.
REQ-007 mem_instr_addr_plus  input  32  instruction address + 4.
REQ-008 mem_result_src  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 treated as 00.
REQ-009 mem_wr_enable  input  1  instruction writes the register file.
REQ-010 mem_funct3  input  3  load size/sign code.
REQ-011 dmem_rdata  input  32  word-aligned data-memory read word.
REQ-012 dmem_rvalid  input  1  dmem_rdata valid this cycle.
REQ-013 wb_stall  output  1  combinational; upstream SHALL hold all mem_* inputs stable while high.
REQ-014 wb_rd  output  5  register-file write index.
REQ-015 wb_data  output  32  register-file write data.
REQ-016 wb_wr_enable  output  1  register-file write strobe, single-cycle pulse.
REQ-017 wb_load_fault  output  1  single-cycle pulse on load timeout.
REQ-018 wb_instret  output  64  retired-instruction count (present only with WB_INSTRET_EN).

Function
REQ-019 FSM states IDLE and WAIT; IDLE -> WAIT when mem_valid, mem_result_src=01 and dmem_rvalid=0; WAIT -> IDLE on dmem_rvalid=1 or timeout.
REQ-020 wb_stall = 1 in WAIT while dmem_rvalid=0, and in IDLE when a load is presented with dmem_rvalid=0; 0 otherwise.
REQ-021 Retire: an instruction retires at the rising edge where mem_valid=1 and wb_stall=0; wb_rd, wb_data, wb_wr_enable update at that edge (latency 1 cycle).
REQ-022 wb_wr_enable = mem_wr_enable AND (mem_rd != 0) on retire; 0 on every other cycle, including stall cycles.
REQ-023 wb_data: 00/11 -> mem_alu_result; 10 -> mem_instr_addr_plus; 01 -> aligned load data; wb_rd/wb_data hold previous values when not retiring.
REQ-024 Load alignment, offset = mem_alu_result[1:0]: 000 LB byte at offset, sign-extended; 001 LH half at offset[1], sign-extended; 100 LBU and 101 LHU zero-extended; 010 and all other codes full word.
REQ-025 Misaligned halfword (offset[0]=1) uses half offset[1]; no fault raised.
REQ-026 Timeout counter clears on entering stall and increments each stalled cycle; on the cycle it equals TIMEOUT_CYCLES-1 with dmem_rvalid still 0, stall drops, the load retires with wb_wr_enable=0, and wb_load_fault pulses at that edge.
REQ-027 dmem_rvalid arriving in the same cycle as the timeout wins: normal load retire, no fault.
REQ-028 dmem_rvalid while no load is pending is ignored.

Reset
REQ-029 On rst_n low, immediately: FSM=IDLE, counter=0, wb_rd=0, wb_data=0, wb_wr_enable=0, wb_load_fault=0, wb_instret=0.
REQ-030 Reset asserted during WAIT abandons the pending load; no write or fault after release.
REQ-031 First retire possible at the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro WB_INSTRET_EN: defined -> wb_instret port exists and increments by 1 on each non-faulted retire (including rd=0), wrapping at 2^64; undefined -> port and counter absent, all other behaviour identical.

Verification
REQ-033 ALU op, rd=5, alu_result=0x0000_1234, src=00 -> next cycle wb_wr_enable=1, wb_rd=5, wb_data=0x0000_1234, wb_stall=0 throughout.
REQ-034 LB, addr=0x...02, dmem_rdata=0x12_80_56_78, rvalid same cycle -> wb_data=0xFFFF_FF80; LBU same inputs -> 0x0000_0080; LH addr offset 2 -> 0x0000_1280.
REQ-035 Load, rvalid delayed 3 cycles -> wb_stall high exactly 3 cycles, single wb_wr_enable pulse on the retire edge, no fault.
REQ-036 Load, rvalid never asserted, TIMEOUT_CYCLES=4 -> stall high 4 cycles, wb_load_fault pulses once, wb_wr_enable stays 0, FSM back in IDLE.
REQ-037 rd=0 with mem_wr_enable=1 -> wb_wr_enable stays 0; with WB_INSTRET_EN, wb_instret still increments by 1.
REQ-038 rst_n pulsed low in WAIT -> outputs 0 asynchronously; later rvalid produces no write.

Source files
------------

// File: rtl/stage_writeback.sv
// stage_writeback: final pipeline stage. It selects the register-file write
// data (ALU result, PC+4 or aligned load data), stalls the pipeline while a
// load waits for dmem_rvalid, and faults a load that waits too long.
// Optional feature: define WB_INSTRET_EN to add the 64-bit wb_instret
// retired-instruction counter port.
module stage_writeback #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_valid,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_alu_result,
   input  logic [31:0] mem_instr_addr_plus,
   input  logic [1:0]  mem_result_src,
   input  logic        mem_wr_enable,
   input  logic [2:0]  mem_funct3,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_rvalid,
   output logic        wb_stall,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_wr_enable,
   output logic        wb_load_fault
`ifdef WB_INSTRET_EN
   ,output logic [63:0] wb_instret
`endif
);

   // Counter value on which a still-unanswered load is abandoned.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t      state_r;
   logic [7:0]  wait_cnt_r;

   logic        load_s;
   logic        timeout_s;
   logic        stall_s;
   logic        retire_s;
   logic        fault_s;
   logic [31:0] result_s;

   // Extract the addressed byte/halfword from the read word and extend it.
   function automatic logic [31:0] align_load(
      input logic [2:0]  f3,
      input logic [1:0]  off,
      input logic [31:0] word
   );
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      case (off)
         2'd0:    byte_v = word[7:0];
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         default: byte_v = word[31:24];
      endcase
      // A halfword at an odd offset simply uses the half selected by off[1].
      if (off[1]) begin
         half_v = word[31:16];
      end else begin
         half_v = word[15:0];
      end
      case (f3)
         3'b000:  align_load = {{24{byte_v[7]}}, byte_v};
         3'b001:  align_load = {{16{half_v[15]}}, half_v};
         3'b100:  align_load = {24'd0, byte_v};
         3'b101:  align_load = {16'd0, half_v};
         default: align_load = word;
      endcase
   endfunction

   // Stall, retire and timeout decisions for the instruction currently presented.
   always_comb begin
      load_s    = mem_valid && (mem_result_src == 2'b01);
      timeout_s = (state_r == S_WAIT) && !dmem_rvalid && (wait_cnt_r == TIMEOUT_LAST);
      case (state_r)
         S_IDLE:  stall_s = load_s && !dmem_rvalid;
         S_WAIT:  stall_s = !dmem_rvalid && !timeout_s;
         default: stall_s = 1'b0;
      endcase
      retire_s = mem_valid && !stall_s;
      fault_s  = retire_s && timeout_s;
   end

   // Write-data select; encoding 11 behaves like the ALU path.
   always_comb begin
      case (mem_result_src)
         2'b01:   result_s = align_load(mem_funct3, mem_alu_result[1:0], dmem_rdata);
         2'b10:   result_s = mem_instr_addr_plus;
         default: result_s = mem_alu_result;
      endcase
   end

   assign wb_stall = stall_s;

   // Load-wait FSM and its timeout counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         wait_cnt_r <= 8'd0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (load_s && !dmem_rvalid) begin
                  state_r    <= S_WAIT;
                  wait_cnt_r <= 8'd0;
               end else begin
                  state_r    <= S_IDLE;
                  wait_cnt_r <= wait_cnt_r;
               end
            end
            S_WAIT: begin
               if (dmem_rvalid || timeout_s) begin
                  state_r    <= S_IDLE;
                  wait_cnt_r <= 8'd0;
               end else begin
                  state_r    <= S_WAIT;
                  wait_cnt_r <= wait_cnt_r + 8'd1;
               end
            end
            default: begin
               state_r    <= S_IDLE;
               wait_cnt_r <= 8'd0;
            end
         endcase
      end
   end

   // Register-file write port; a faulted load leaves rd/data untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_rd         <= 5'd0;
         wb_data       <= 32'd0;
         wb_wr_enable  <= 1'b0;
         wb_load_fault <= 1'b0;
      end else if (fault_s) begin
         wb_rd         <= wb_rd;
         wb_data       <= wb_data;
         wb_wr_enable  <= 1'b0;
         wb_load_fault <= 1'b1;
      end else if (retire_s) begin
         wb_rd         <= mem_rd;
         wb_data       <= result_s;
         wb_wr_enable  <= mem_wr_enable && (mem_rd != 5'd0);
         wb_load_fault <= 1'b0;
      end else begin
         wb_rd         <= wb_rd;
         wb_data       <= wb_data;
         wb_wr_enable  <= 1'b0;
         wb_load_fault <= 1'b0;
      end
   end

`ifdef WB_INSTRET_EN
   // Count every retire that was not a timed-out load, rd=0 included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_instret <= 64'd0;
      end else if (retire_s && !fault_s) begin
         wb_instret <= wb_instret + 64'd1;
      end else begin
         wb_instret <= wb_instret;
      end
   end
`else
   // Without WB_INSTRET_EN there is no retired-instruction counter.
`endif

endmodule

// File: tb/tb_stage_writeback.sv
// Self-checking bench for stage_writeback (TIMEOUT_CYCLES = 4). Each
// instruction's stall length and outcome come from its rvalid delay; a
// per-cycle compare process checks every output against that model.
module tb_stage_writeback;

   localparam int TO    = 4;
   localparam int NEVER = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid;
   logic [4:0]  mem_rd;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_instr_addr_plus;
   logic [1:0]  mem_result_src;
   logic        mem_wr_enable;
   logic [2:0]  mem_funct3;
   logic [31:0] dmem_rdata;
   logic        dmem_rvalid;
   logic        wb_stall;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_wr_enable;
   logic        wb_load_fault;
`ifdef WB_INSTRET_EN
   logic [63:0] wb_instret;
`endif

   stage_writeback #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_rd(mem_rd),
      .mem_alu_result(mem_alu_result), .mem_instr_addr_plus(mem_instr_addr_plus),
      .mem_result_src(mem_result_src), .mem_wr_enable(mem_wr_enable),
      .mem_funct3(mem_funct3), .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
      .wb_stall(wb_stall), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_wr_enable(wb_wr_enable), .wb_load_fault(wb_load_fault)
`ifdef WB_INSTRET_EN
      ,.wb_instret(wb_instret)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          stall_seen = 0;
   int          fault_seen = 0;
   logic        check_en = 1'b0;

   // Model state: what the registered outputs must show, plus the outcome of
   // the cycle now being presented (applied at the next rising edge).
   logic        exp_stall = 1'b0;
   logic [4:0]  m_rd = 5'd0;
   logic [31:0] m_data = 32'd0;
   logic        m_we = 1'b0;
   logic        m_fault = 1'b0;
   logic [63:0] m_instret = 64'd0;
   int          pend_kind = 0;   // 0 nothing, 1 retire, 2 fault
   logic [4:0]  pend_rd = 5'd0;
   logic [31:0] pend_data = 32'd0;
   logic        pend_we = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Load result from the architectural rules (shift, then sign/zero extend).
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] w);
      logic [31:0] bsh;
      logic [31:0] hsh;
      bsh = w >> (8 * int'(addr[1:0]));
      hsh = w >> (16 * int'(addr[1]));
      case (f3)
         3'b000:  ref_load = 32'(signed'(bsh[7:0]));
         3'b001:  ref_load = 32'(signed'(hsh[15:0]));
         3'b100:  ref_load = 32'(bsh[7:0]);
         3'b101:  ref_load = 32'(hsh[15:0]);
         default: ref_load = w;
      endcase
   endfunction

   task automatic apply_pend();
      if (pend_kind == 1) begin
         m_rd = pend_rd; m_data = pend_data; m_we = pend_we; m_fault = 1'b0;
         m_instret = m_instret + 64'd1;
      end else if (pend_kind == 2) begin
         m_we = 1'b0; m_fault = 1'b1;
      end else begin
         m_we = 1'b0; m_fault = 1'b0;
      end
   endtask

   // Present one instruction; rvalid arrives 'delay' cycles after it appears.
   task automatic run_instr(input logic v, input logic [4:0] rd, input logic [31:0] alu,
                            input logic [31:0] pc4, input logic [1:0] src, input logic we,
                            input logic [2:0] f3, input logic [31:0] rdata,
                            input int delay, input logic noise_rv);
      logic is_load, faulted;
      int nstall;
      logic [31:0] res;
      is_load = v && (src == 2'b01);
      faulted = is_load && (delay > TO);
      nstall  = !is_load ? 0 : ((delay > TO) ? TO : delay);
      if (src == 2'b01) res = ref_load(f3, alu, rdata);
      else if (src == 2'b10) res = pc4;
      else res = alu;
      for (int c = 0; c <= nstall; c++) begin
         @(posedge clk);
         apply_pend();
         #1;
         mem_valid = v; mem_rd = rd; mem_alu_result = alu; mem_instr_addr_plus = pc4;
         mem_result_src = src; mem_wr_enable = we; mem_funct3 = f3; dmem_rdata = rdata;
         dmem_rvalid = is_load ? (!faulted && c == delay) : noise_rv;
         exp_stall = (c < nstall);
         pend_rd = rd; pend_data = res; pend_we = we && (rd != 5'd0);
         if (v && c == nstall) pend_kind = faulted ? 2 : 1;
         else pend_kind = 0;
      end
   endtask

   task automatic idle();
      run_instr(1'b0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, 3'b000, 32'd0, 0, 1'b0);
   endtask

   // One idle cycle so the last retire becomes visible, then a literal check.
   task automatic lit_data(input string name, input logic [31:0] exp);
      idle();
      @(negedge clk); #1;
      chk(name, {32'd0, wb_data}, {32'd0, exp});
   endtask

   // Compare process: every falling edge, all outputs against the model.
   task automatic compare_loop();
      forever begin
         @(negedge clk);
         if (check_en) begin
            chk("stall", {63'd0, wb_stall}, {63'd0, exp_stall});
            chk("wr_enable", {63'd0, wb_wr_enable}, {63'd0, m_we});
            chk("rd", {59'd0, wb_rd}, {59'd0, m_rd});
            chk("data", {32'd0, wb_data}, {32'd0, m_data});
            chk("load_fault", {63'd0, wb_load_fault}, {63'd0, m_fault});
`ifdef WB_INSTRET_EN
            chk("instret", wb_instret, m_instret);
`endif
            stall_seen += int'(wb_stall);
            fault_seen += int'(wb_load_fault);
         end
      end
   endtask

   initial begin
      int s0, f0;
      logic [63:0] i0;
      fork
         compare_loop();
      join_none
      rst_n = 1'b0; mem_valid = 1'b0; mem_rd = 5'd0; mem_alu_result = 32'd0;
      mem_instr_addr_plus = 32'd0; mem_result_src = 2'b00; mem_wr_enable = 1'b0;
      mem_funct3 = 3'b000; dmem_rdata = 32'd0; dmem_rvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_enable", {63'd0, wb_wr_enable}, 64'd0);
      chk("rst_data", {32'd0, wb_data}, 64'd0);
      chk("rst_fault", {63'd0, wb_load_fault}, 64'd0);
      @(negedge clk); #2;
      rst_n = 1'b1; check_en = 1'b1;

      // ALU op, rd=5.
      run_instr(1'b1, 5'd5, 32'h0000_1234, 32'h104, 2'b00, 1'b1, 3'b000, 32'd0, 0, 1'b0);
      idle();
      @(negedge clk); #1;
      chk("alu_we", {63'd0, wb_wr_enable}, 64'd1);
      chk("alu_rd", {59'd0, wb_rd}, 64'd5);
      chk("alu_data", {32'd0, wb_data}, 64'h1234);

      // Load alignment, rvalid in the same cycle.
      run_instr(1'b1, 5'd6, 32'h0000_0102, 32'h0, 2'b01, 1'b1, 3'b000, 32'h1280_5678, 0, 1'b0);
      lit_data("lb", 32'hFFFF_FF80);
      run_instr(1'b1, 5'd6, 32'h0000_0102, 32'h0, 2'b01, 1'b1, 3'b100, 32'h1280_5678, 0, 1'b0);
      lit_data("lbu", 32'h0000_0080);
      run_instr(1'b1, 5'd7, 32'h0000_0102, 32'h0, 2'b01, 1'b1, 3'b001, 32'h1280_5678, 0, 1'b0);
      lit_data("lh_off2", 32'h0000_1280);
      run_instr(1'b1, 5'd7, 32'h0000_0100, 32'h0, 2'b01, 1'b1, 3'b101, 32'h1280_5678, 0, 1'b0);
      lit_data("lhu_off0", 32'h0000_5678);
      run_instr(1'b1, 5'd8, 32'h0000_0103, 32'h0, 2'b01, 1'b1, 3'b001, 32'h9ABC_5678, 0, 1'b0);
      lit_data("lh_misaligned", 32'hFFFF_9ABC);
      run_instr(1'b1, 5'd8, 32'h0000_0101, 32'h0, 2'b01, 1'b1, 3'b000, 32'h1280_5678, 0, 1'b0);
      lit_data("lb_off1", 32'h0000_0056);
      run_instr(1'b1, 5'd9, 32'h0000_0101, 32'h0, 2'b01, 1'b1, 3'b010, 32'h1280_5678, 0, 1'b0);
      lit_data("lw", 32'h1280_5678);
      run_instr(1'b1, 5'd9, 32'h0000_0100, 32'h0, 2'b01, 1'b1, 3'b011, 32'hCAFE_F00D, 0, 1'b0);
      lit_data("f3_other", 32'hCAFE_F00D);

      // PC+4 and the 11 encoding.
      run_instr(1'b1, 5'd1, 32'h1111_1111, 32'h2000_0008, 2'b10, 1'b1, 3'b000, 32'd0, 0, 1'b0);
      lit_data("pc_plus4", 32'h2000_0008);
      run_instr(1'b1, 5'd2, 32'hDEAD_BEEF, 32'h2000_000C, 2'b11, 1'b1, 3'b000, 32'd0, 0, 1'b0);
      lit_data("src11_alu", 32'hDEAD_BEEF);

      // Load with rvalid 3 cycles late: three stall cycles, no fault.
      s0 = stall_seen; f0 = fault_seen;
      run_instr(1'b1, 5'd10, 32'h0000_0200, 32'h0, 2'b01, 1'b1, 3'b010, 32'hA5A5_0001, 3, 1'b0);
      lit_data("late_load", 32'hA5A5_0001);
      chk("late_stall_cycles", 64'(stall_seen - s0), 64'd3);
      chk("late_no_fault", 64'(fault_seen - f0), 64'd0);

      // Load never answered: timeout fault, rd/data keep previous values.
      s0 = stall_seen; f0 = fault_seen;
      run_instr(1'b1, 5'd11, 32'h0000_0300, 32'h0, 2'b01, 1'b1, 3'b010, 32'h7777_7777, NEVER, 1'b0);
      lit_data("timeout_data_held", 32'hA5A5_0001);
      chk("timeout_stall_cycles", 64'(stall_seen - s0), 64'd4);
      chk("timeout_fault_pulses", 64'(fault_seen - f0), 64'd1);

      // rvalid on the timeout cycle wins.
      s0 = stall_seen; f0 = fault_seen;
      run_instr(1'b1, 5'd12, 32'h0000_0400, 32'h0, 2'b01, 1'b1, 3'b010, 32'h0BAD_CAFE, TO, 1'b0);
      lit_data("rvalid_at_timeout", 32'h0BAD_CAFE);
      chk("race_no_fault", 64'(fault_seen - f0), 64'd0);
      chk("race_stall_cycles", 64'(stall_seen - s0), 64'd4);

      // rd=0 with write enable; write enable clear.
`ifdef WB_INSTRET_EN
      i0 = wb_instret;
`else
      i0 = 64'd0;
`endif
      run_instr(1'b1, 5'd0, 32'h0000_5555, 32'h0, 2'b00, 1'b1, 3'b000, 32'd0, 0, 1'b0);
      idle();
      @(negedge clk); #1;
      chk("rd0_no_write", {63'd0, wb_wr_enable}, 64'd0);
`ifdef WB_INSTRET_EN
      chk("rd0_instret", wb_instret - i0, 64'd1);
`endif
      run_instr(1'b1, 5'd13, 32'h0000_6666, 32'h0, 2'b00, 1'b0, 3'b000, 32'd0, 0, 1'b0);
      lit_data("we0_data", 32'h0000_6666);

      // Stray rvalid with no pending load.
      run_instr(1'b0, 5'd14, 32'h0, 32'h0, 2'b01, 1'b1, 3'b000, 32'hFFFF_FFFF, 0, 1'b1);
      run_instr(1'b1, 5'd15, 32'h0000_0777, 32'h0, 2'b00, 1'b1, 3'b000, 32'hFFFF_FFFF, 0, 1'b1);
      lit_data("stray_rvalid", 32'h0000_0777);

      // Back-to-back ALU ops.
      for (int k = 0; k < 4; k++) begin
         run_instr(1'b1, 5'(16 + k), 32'h0001_0000 + 32'(k), 32'h0, 2'b00, 1'b1, 3'b000, 32'd0, 0, 1'b0);
      end
      lit_data("b2b_last", 32'h0001_0003);

      // Reset while a load waits: outputs clear at once, later rvalid writes nothing.
      @(posedge clk); apply_pend(); #1;
      mem_valid = 1'b1; mem_rd = 5'd20; mem_alu_result = 32'h0000_0500; mem_result_src = 2'b01;
      mem_wr_enable = 1'b1; mem_funct3 = 3'b010; dmem_rdata = 32'h1357_9BDF; dmem_rvalid = 1'b0;
      exp_stall = 1'b1; pend_kind = 0;
      @(posedge clk); apply_pend(); #1;
      exp_stall = 1'b1; pend_kind = 0;
      @(posedge clk); #2;
      rst_n = 1'b0; check_en = 1'b0;
      #1;
      chk("async_rst_we", {63'd0, wb_wr_enable}, 64'd0);
      chk("async_rst_rd", {59'd0, wb_rd}, 64'd0);
      chk("async_rst_data", {32'd0, wb_data}, 64'd0);
      chk("async_rst_fault", {63'd0, wb_load_fault}, 64'd0);
      mem_valid = 1'b0;
      m_rd = 5'd0; m_data = 32'd0; m_we = 1'b0; m_fault = 1'b0; m_instret = 64'd0;
      pend_kind = 0; exp_stall = 1'b0;
      @(negedge clk); #2;
      rst_n = 1'b1; check_en = 1'b1;
      run_instr(1'b0, 5'd20, 32'h0000_0500, 32'h0, 2'b01, 1'b1, 3'b010, 32'h1357_9BDF, 0, 1'b1);
      lit_data("after_rst_no_write", 32'h0000_0000);
      run_instr(1'b1, 5'd21, 32'h0000_0ABC, 32'h0, 2'b00, 1'b1, 3'b000, 32'd0, 0, 1'b0);
      lit_data("after_rst_alu", 32'h0000_0ABC);
      idle();
      @(negedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
